// File: rtl/onehot_index_encoder.sv
// Purpose: accepts a WIDTH-bit vector and emits the index of each set bit, lowest first.
// Latency: the first beat appears one cycle after capture, then one beat per accepted cycle.
// Backpressure: out_ready stalls the drain with all outputs held; in_ready stays low until the last beat.
module onehot_index_encoder #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero,
    output logic [IDX_W:0]   out_pop
);

    generate
        if (IDX_W != $clog2(WIDTH)) begin : g_cfg_err
            $error("onehot_index_encoder: IDX_W must equal clog2(WIDTH)");
        end
    endgenerate

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pending, pending_nxt, pending_rest;
    logic             zero_q;
    logic [IDX_W:0]   pop_q;
    logic             load;

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // pending with its lowest set bit removed; nonzero means more beats follow
    assign pending_rest = pending & (pending - WIDTH'(1));

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        load        = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    pending_nxt = in_vec;
                    state_nxt   = DRAIN;
                    load        = 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (pending_rest == '0) begin
                        pending_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        pending_nxt = pending_rest;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            zero_q  <= 1'b0;
            pop_q   <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (load) begin
                zero_q <= (in_vec == '0);
                pop_q  <= popcount(in_vec);
            end
        end
    end

    always_comb begin
        out_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) out_idx = IDX_W'(i);
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DRAIN);
    // gated by out_valid so an idle block reports last=0 even though pending is empty
    assign out_last  = out_valid && (pending_rest == '0);
    assign out_zero  = zero_q;
    assign out_pop   = pop_q;

endmodule

// File: doc/onehot_index_encoder.md
Name: onehot_index_encoder

Overview:
- Inverse direction of the team's 4-to-16 enable decoder: turns a 16-bit bit-vector back into 4-bit indices.
- Accepts one vector per transaction over a valid/ready input.
- Then emits the index of every set bit, lowest first, one per output handshake, with a last flag and a captured population count.
- Sits between request/flag sources (interrupt lines, one-hot grants) and logic that consumes binary indices.

Parameters:
- WIDTH, 16, input vector width.
- IDX_W, 4, index width. Must equal clog2(WIDTH); any other value is a configuration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector
- in_vec  input  WIDTH  bit-vector to encode
- out_valid  output  1  out_idx/out_last/out_zero/out_pop are valid
- out_ready  input  1  consumer accepts the current beat
- out_idx  output  IDX_W  index of the lowest remaining set bit
- out_last  output  1  current beat is the final beat of this vector
- out_zero  output  1  captured vector was all zeros
- out_pop  output  IDX_W+1  number of set bits in the captured vector, 0..WIDTH

Behaviour:
- Reset and clocking:
  - One clock domain.
  - Reset is synchronous, active-high, and has priority over all other events.
  - Reset values: state=IDLE, pending=0, in_ready=1, out_valid=0, out_idx=0, out_last=0, out_zero=0, out_pop=0.
- Internal registers:
  - state: IDLE or DRAIN.
  - pending[WIDTH-1:0]: remaining set bits.
  - zero flag.
  - pop[IDX_W:0].
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at edge N: pending<=in_vec, pop<=popcount(in_vec), zero<=(in_vec==0), state<=DRAIN.
- DRAIN:
  - in_ready=0; in_valid is ignored and in_vec is not sampled.
  - out_valid=1, starting in cycle N+1 (one-cycle capture latency).
- Output decode (combinational from registers):
  - out_idx = position of the lowest set bit of pending; 0 when pending==0.
  - out_last = 1 when pending has at most one bit set.
  - out_zero = zero flag.
  - out_pop = pop; constant for the whole transaction.
- Beat handshake in DRAIN:
  - Handshake occurs when out_valid && out_ready.
  - Non-last beat: clear the lowest set bit of pending (pending <= pending & (pending-1)) and stay in DRAIN.
  - Last beat: pending<=0, state<=IDLE, so in_ready=1 in the following cycle.
- Stall: while out_valid && !out_ready, every output holds stable and pending is unchanged.
- Zero vector: exactly one beat with out_idx=0, out_last=1, out_zero=1, out_pop=0.
- Throughput:
  - One beat per cycle when out_ready is held high.
  - A vector with k set bits occupies 1 capture cycle plus max(k,1) beat cycles.
  - No overlap between the input and output phases.
- Reset mid-DRAIN: pending is discarded with no further beats; in_ready=1 in the cycle after the reset edge.
- Reset asserted in the same cycle as an input handshake: the reset wins and the vector is dropped.
- Boundaries:
  - Bit WIDTH-1 yields out_idx=WIDTH-1 (15).
  - All-ones yields out_pop=16 (5'b10000), which must not wrap.

Test Plan:
- in_vec=16'h0001, out_ready=1 -> one beat idx=0, last=1, zero=0, pop=1; in_ready high in the next cycle.
- in_vec=16'h8421, out_ready=1 -> beats idx 0,5,10,15 on consecutive cycles; last only on idx 15; pop=4 on every beat.
- in_vec=16'h0000 -> single beat idx=0, last=1, zero=1, pop=0; then return to IDLE.
- in_vec=16'hFFFF, out_ready toggled pseudo-randomly -> 16 beats idx 0..15 in order; outputs stable during every stall; pop=16; last only on idx 15.
- in_vec=16'h00F0 with in_valid held high and in_vec changed to 16'h0001 during DRAIN -> emits 4,5,6,7 only; the 16'h0001 vector is not accepted until in_ready returns high.
- rst pulsed for one cycle after the second beat of 16'h0303 -> no further beats, out_valid=0 and in_ready=1 the cycle after the reset edge; the next vector 16'h4000 yields idx=14, last=1.
